// File: rtl/i2c_packet_tx_if.sv
// Control-side handshake of i2c_packet_tx: trigger and payload in, frame status out.
// The I2C pins themselves stay plain ports on the block so they map straight to pads.
interface i2c_packet_tx_if #(
  parameter int NUM_BYTES = 3
);
  logic                   send_trigger;
  logic [8*NUM_BYTES-1:0] payload;
  logic                   is_transfer;
  logic                   done;
  logic                   nack_err;
  logic [1:0]             retry_cnt;

  modport master (
    output send_trigger,
    output payload,
    input  is_transfer,
    input  done,
    input  nack_err,
    input  retry_cnt
  );

  modport slave (
    input  send_trigger,
    input  payload,
    output is_transfer,
    output done,
    output nack_err,
    output retry_cnt
  );
endinterface

// File: rtl/i2c_packet_tx.sv
// Write-only I2C master: per trigger sends {SLV_ADDR,W} then NUM_BYTES payload bytes.
// Optional macro I2C_PACKET_RETRY_EN re-sends a NACKed frame up to 3 times.
module i2c_packet_tx #(
  parameter int         NUM_BYTES = 3,
  parameter logic [6:0] SLV_ADDR  = 7'h52,
  parameter int         CLK_DIV   = 250
) (
  input  logic           clk,
  input  logic           reset,
  i2c_packet_tx_if.slave ctrl,
  output logic           SCL,
  inout  wire            SDA
);

  localparam int            QW        = $clog2(CLK_DIV);
  localparam logic [7:0]    ADDR_BYTE = {SLV_ADDR, 1'b0};
  localparam logic [QW-1:0] Q_LAST    = QW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST_BYTE = 4'(NUM_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  state_t                 r_state;
  logic [QW-1:0]          r_qcnt;
  logic [1:0]             r_phase;
  logic [2:0]             r_bit;
  logic [3:0]             r_byte;
  logic [7:0]             r_shift;
  logic [8*NUM_BYTES-1:0] r_payload;
  logic                   r_ack_nack;
  logic                   r_scl;
  logic                   r_sda_low;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_nack;
  logic [1:0]             r_retry;

  logic                   w_q_end;
  logic [8*NUM_BYTES-1:0] w_pl_sh;
  logic [7:0]             w_next_byte;
  logic                   w_last_byte;
  logic                   w_retry;

  assign w_q_end     = (r_qcnt == Q_LAST);
  // r_byte indexes the byte just acknowledged (0 = address), so payload byte r_byte is next
  assign w_pl_sh     = r_payload << {r_byte, 3'b000};
  assign w_next_byte = w_pl_sh[8*NUM_BYTES-1 -: 8];
  assign w_last_byte = (r_byte == LAST_BYTE);

`ifdef I2C_PACKET_RETRY_EN
  assign w_retry = r_ack_nack && (r_retry != 2'd3);
`else
  assign w_retry = 1'b0;
`endif

  // Frame sequencer: outputs are loaded for the quarter that starts at each update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_qcnt     <= {QW{1'b0}};
      r_phase    <= 2'd0;
      r_bit      <= 3'd0;
      r_byte     <= 4'd0;
      r_shift    <= 8'd0;
      r_payload  <= {(8*NUM_BYTES){1'b0}};
      r_ack_nack <= 1'b0;
      r_scl      <= 1'b1;
      r_sda_low  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_nack     <= 1'b0;
      r_retry    <= 2'd0;
    end else begin
      r_done <= 1'b0;
      r_nack <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_qcnt    <= {QW{1'b0}};
        r_phase   <= 2'd0;
        r_scl     <= 1'b1;
        r_sda_low <= 1'b0;
        if (ctrl.send_trigger) begin
          r_payload <= ctrl.payload;
          r_retry   <= 2'd0;
          r_busy    <= 1'b1;
          r_state   <= ST_START;
        end
      end else if (!w_q_end) begin
        r_qcnt <= r_qcnt + QW'(1'b1);
      end else begin
        r_qcnt  <= {QW{1'b0}};
        r_phase <= r_phase + 2'd1;
        case (r_state)
          ST_START: begin
            case (r_phase)
              2'd0: r_sda_low <= 1'b1;
              2'd1: r_scl     <= 1'b0;
              2'd3: begin
                r_state   <= ST_BIT;
                r_byte    <= 4'd0;
                r_bit     <= 3'd7;
                r_shift   <= ADDR_BYTE;
                r_sda_low <= ~ADDR_BYTE[7];
              end
              default: r_scl <= 1'b0;
            endcase
          end
          ST_BIT: begin
            case (r_phase)
              2'd1: r_scl <= 1'b1;
              2'd3: begin
                r_scl <= 1'b0;
                if (r_bit == 3'd0) begin
                  r_state   <= ST_ACK;
                  r_sda_low <= 1'b0;
                end else begin
                  r_bit     <= r_bit - 3'd1;
                  r_shift   <= {r_shift[6:0], 1'b0};
                  r_sda_low <= ~r_shift[6];
                end
              end
              default: r_scl <= r_scl;
            endcase
          end
          ST_ACK: begin
            case (r_phase)
              2'd1: r_scl      <= 1'b1;
              2'd2: r_ack_nack <= SDA;
              2'd3: begin
                r_scl <= 1'b0;
                if (r_ack_nack || w_last_byte) begin
                  r_state   <= ST_STOP;
                  r_sda_low <= 1'b1;
                end else begin
                  r_state   <= ST_BIT;
                  r_byte    <= r_byte + 4'd1;
                  r_bit     <= 3'd7;
                  r_shift   <= w_next_byte;
                  r_sda_low <= ~w_next_byte[7];
                end
              end
              default: r_scl <= r_scl;
            endcase
          end
          ST_STOP: begin
            case (r_phase)
              2'd1: r_scl     <= 1'b1;
              2'd2: r_sda_low <= 1'b0;
              2'd3: begin
                if (w_retry) begin
                  r_state <= ST_WAIT;
                  r_retry <= r_retry + 2'd1;
                end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= ~r_ack_nack;
                  r_nack  <= r_ack_nack;
                end
              end
              default: r_scl <= r_scl;
            endcase
          end
          ST_WAIT: begin
            if (r_phase == 2'd3) begin
              r_state <= ST_START;
            end else begin
              r_state <= ST_WAIT;
            end
          end
          default: begin
            // Unreachable encodings: release the bus and fall back to idle
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SCL              = r_scl;
  assign SDA              = r_sda_low ? 1'b0 : 1'bz;
  assign ctrl.is_transfer = r_busy;
  assign ctrl.done        = r_done;
  assign ctrl.nack_err    = r_nack;
  assign ctrl.retry_cnt   = r_retry;

endmodule

// File: tb/tb_i2c_packet_tx.sv
// Scoreboard bench for i2c_packet_tx: a bus-level slave decodes bytes and answers ACK/NACK
// from a per-attempt plan; expected bytes and frame outcomes come from a frame-level model.
module tb_i2c_packet_tx;
  localparam int         NB   = 3;
  localparam int         CD   = 2;
  localparam logic [6:0] ADDR = 7'h52;
`ifdef I2C_PACKET_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct {
    bit is_done;
    int retry;
    int start;
    int len;
    int starts;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic scl;
  wire  sda;
  logic slv_low = 1'b0;

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_packet_tx_if #(.NUM_BYTES(NB)) ifc ();

  i2c_packet_tx #(.NUM_BYTES(NB), .SLV_ADDR(ADDR), .CLK_DIV(CD)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ifc.slave),
    .SCL   (scl),
    .SDA   (sda)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         busy_cnt = 0;
  int         starts = 0;
  int         plan [4];
  exp_t       exp_out [$];
  logic [7:0] exp_bytes [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] frame_byte(input logic [8*NB-1:0] pl, input int k);
    logic [8*NB-1:0] t;
    if (k == 0) return {ADDR, 1'b0};
    t = pl >> (8 * (NB - k));
    return t[7:0];
  endfunction

  // Issue one trigger; the model lays out every attempt the slave plan implies
  task automatic send(input logic [8*NB-1:0] pl);
    exp_t e;
    int   att;
    int   j;
    int   nsent;
    bit   fin;
    @(negedge clk);
    ifc.payload      = pl;
    ifc.send_trigger = 1'b1;
    starts   = 0;
    e.start  = cyc + 1;
    e.len    = 0;
    e.is_done = 1'b0;
    e.retry  = 0;
    att      = 0;
    fin      = 1'b0;
    while (!fin) begin
      j     = plan[att];
      nsent = (j < 0) ? NB + 1 : j + 1;
      for (int k = 0; k < nsent; k++) exp_bytes.push_back(frame_byte(pl, k));
      e.len += (2 + 9 * nsent) * 4 * CD;
      if (j < 0) begin
        e.is_done = 1'b1;
        e.retry   = att;
        fin       = 1'b1;
      end else if (RETRY && att < 3) begin
        e.len += 4 * CD;
        att++;
      end else begin
        e.is_done = 1'b0;
        e.retry   = att;
        fin       = 1'b1;
      end
    end
    e.starts = att + 1;
    exp_out.push_back(e);
    @(negedge clk);
    ifc.send_trigger = 1'b0;
    ifc.payload      = 24'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (exp_out.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, 32'(exp_out.size()), 32'd0);
    exp_out.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
    plan[0] = p0;
    plan[1] = p1;
    plan[2] = p2;
    plan[3] = p3;
  endtask

  // Bus-level slave: START/bit decode on SCL edges, ACK or NACK per the plan
  initial begin
    logic       p_scl;
    logic       p_sda;
    logic [7:0] cur;
    int         bitcnt;
    int         bytei;
    int         idx;
    p_scl  = 1'b1;
    p_sda  = 1'b1;
    cur    = 8'd0;
    bitcnt = 0;
    bytei  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        slv_low = 1'b0;
        bitcnt  = 0;
        bytei   = 0;
        cur     = 8'd0;
      end else if (scl && p_scl && p_sda && !sda) begin
        starts++;
        bitcnt  = 0;
        bytei   = 0;
        cur     = 8'd0;
        slv_low = 1'b0;
      end else if (!p_scl && scl) begin
        if (bitcnt < 8) begin
          cur = {cur[6:0], sda};
          bitcnt++;
          if (bitcnt == 8) begin
            if (exp_bytes.size() == 0) chk("unexpected_byte", 32'(cur), 32'hFFFF_FFFF);
            else chk("sda_byte", 32'(cur), 32'(exp_bytes.pop_front()));
          end
        end
      end else if (p_scl && !scl) begin
        if (bitcnt == 8) begin
          idx     = (starts >= 1 && starts <= 4) ? starts - 1 : 3;
          slv_low = (plan[idx] != bytei);
          bitcnt  = 9;
        end else if (bitcnt == 9) begin
          slv_low = 1'b0;
          bitcnt  = 0;
          bytei++;
        end
      end
      p_scl = scl;
      p_sda = sda;
    end
  end

  // Monitor: per-cycle bus sanity plus scoreboard pop on every done/nack_err pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (ifc.is_transfer) busy_cnt++;
        if (ifc.done && ifc.nack_err) chk("done_and_nack", 32'd1, 32'd0);
        if (slv_low) chk("sda_not_driven_high", 32'(sda), 32'd0);
        if (!ifc.is_transfer) begin
          chk("idle_scl", 32'(scl), 32'd1);
          chk("idle_sda", 32'(sda), 32'd1);
        end
        if (ifc.done || ifc.nack_err) begin
          if (exp_out.size() == 0) begin
            chk("unexpected_pulse", 32'd1, 32'd0);
          end else begin
            e = exp_out.pop_front();
            chk("pulse_done",   32'(ifc.done),      32'(e.is_done));
            chk("pulse_nack",   32'(ifc.nack_err),  32'(!e.is_done));
            chk("retry_cnt",    32'(ifc.retry_cnt), 32'(e.retry));
            chk("frame_cycles", 32'(cyc - e.start), 32'(e.len));
            chk("busy_cycles",  32'(busy_cnt),      32'(e.len));
            chk("start_count",  32'(starts),        32'(e.starts));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    ifc.send_trigger = 1'b0;
    ifc.payload      = {(8*NB){1'b0}};
    set_plan(-1, -1, -1, -1);
    repeat (4) @(negedge clk);
    chk("rst_scl",   32'(scl),             32'd1);
    chk("rst_sda",   32'(sda),             32'd1);
    chk("rst_busy",  32'(ifc.is_transfer), 32'd0);
    chk("rst_done",  32'(ifc.done),        32'd0);
    chk("rst_nack",  32'(ifc.nack_err),    32'd0);
    chk("rst_retry", 32'(ifc.retry_cnt),   32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    set_plan(-1, -1, -1, -1);
    send(24'hA1B2C3);
    wait_idle("all_ack");

    set_plan(0, 0, 0, 0);
    send(24'h0F1E2D);
    wait_idle("addr_nack");

    set_plan(0, 0, -1, -1);
    send(24'h3C4B5A);
    wait_idle("nack_twice");

    set_plan(-1, -1, -1, -1);
    send(24'h123456);
    repeat (60) @(negedge clk);
    ifc.payload      = 24'h5A5A5A;
    ifc.send_trigger = 1'b1;
    @(negedge clk);
    ifc.send_trigger = 1'b0;
    wait_idle("ignored_trigger");

    set_plan(-1, -1, -1, -1);
    send(24'($urandom));
    repeat (114) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_scl",  32'(scl),             32'd1);
    chk("abort_sda",  32'(sda),             32'd1);
    chk("abort_busy", 32'(ifc.is_transfer), 32'd0);
    exp_out.delete();
    exp_bytes.delete();
    busy_cnt = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (400) @(negedge clk);
    send(24'($urandom));
    wait_idle("after_abort");

    for (int f = 0; f < 10; f++) begin
      int n_nack;
      n_nack = RETRY ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 1));
      for (int a = 0; a < 4; a++) plan[a] = (a < n_nack) ? int'($urandom_range(0, NB)) : -1;
      send(24'($urandom));
      wait_idle("random");
    end

    chk("bytes_left", 32'(exp_bytes.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
